// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MFHI  = 4'd1,
    OP_MFLO  = 4'd2,
    OP_MTHI  = 4'd3,
    OP_MTLO  = 4'd4,
    OP_MULT  = 4'd5,
    OP_MULTU = 4'd6,
    OP_DIV   = 4'd7,
    OP_DIVU  = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_LO   = 2'b01;
  localparam logic [1:0] WE_HI   = 2'b10;
  localparam logic [1:0] WE_BOTH = 2'b11;

  // Any op that touches HI/LO (MF, MT, MUL, DIV); 0 and 9..15 behave as NOP.
  function automatic logic is_hilo_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: one shift-add multiply or restoring-divide step per cycle.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] res_nxt_o
);

  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             div_q;
  logic [WIDTH:0]   sum, shl;
  logic [WIDTH-1:0] diff;

  // Multiply: lo holds the multiplier and shifts out LSB-first while the
  // product fills in from the top. Divide: {hi,lo} shifts left, hi is the
  // partial remainder, quotient bits enter lo from the bottom.
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shl  = {hi_q, lo_q[WIDTH-1]};
    diff = shl[WIDTH-1:0] - b_q;
    hi_d = sum[WIDTH:1];
    lo_d = {sum[0], lo_q[WIDTH-1:1]};
    if (div_q) begin
      if (shl >= {1'b0, b_q}) begin
        hi_d = diff;
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shl[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign res_nxt_o = {hi_d, lo_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (start_i) begin
      hi_q  <= '0;
      lo_q  <= a_i;
      b_q   <= b_i;
      div_q <= div_i;
    end else if (step_i) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: accepts MT/MUL/DIV from EX, runs the iterative core, drives HI/LO writes and stall.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               flush,
  output logic               stall,
  output logic               busy,
  output logic [1:0]         hilo_we,
  output logic [2*WIDTH-1:0] hilo_wdata,
  output logic               hilo_rd_sel
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               qneg_q, rneg_q, dz_q, busy_q;
  logic [WIDTH-1:0]   a_q;
  logic [1:0]         we_q;
  logic [2*WIDTH-1:0] wdata_q;

  logic               is_mul, is_div, is_mt, is_sgn, accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b, q_fix, r_fix;
  logic [2*WIDTH-1:0] core_res, prod_fix, div_res, final_res;

  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_mt  = (op == OP_MTHI) || (op == OP_MTLO);
  assign is_sgn = (op == OP_MULT) || (op == OP_DIV);
  assign accept = op_valid && (state_q == S_IDLE) && !flush && (is_mul || is_div || is_mt);

  // Magnitudes are unsigned, so 0x80000000 survives negation as 2^31.
  assign a_neg = is_sgn && src_a[WIDTH-1];
  assign b_neg = is_sgn && src_b[WIDTH-1];
  assign mag_a = a_neg ? -src_a : src_a;
  assign mag_b = b_neg ? -src_b : src_b;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept && (is_mul || is_div)),
    .step_i    ((state_q == S_MUL) || (state_q == S_DIV)),
    .div_i     (is_div),
    .a_i       (mag_a),
    .b_i       (mag_b),
    .res_nxt_o (core_res)
  );

  // Sign fix-up on the value the core produces on its final step.
  always_comb begin
    prod_fix  = qneg_q ? -core_res : core_res;
    q_fix     = qneg_q ? -core_res[WIDTH-1:0] : core_res[WIDTH-1:0];
    r_fix     = rneg_q ? -core_res[2*WIDTH-1:WIDTH] : core_res[2*WIDTH-1:WIDTH];
    div_res   = dz_q ? {a_q, {WIDTH{1'b1}}} : {r_fix, q_fix};
    final_res = (state_q == S_DIV) ? div_res : prod_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
      we_q    <= WE_NONE;
      wdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      we_q <= WE_NONE;
      case (state_q)
        S_IDLE: if (accept) begin
          a_q    <= src_a;
          qneg_q <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          dz_q   <= (src_b == '0);
          cnt_q  <= '0;
          busy_q <= 1'b1;
          if (is_mt) begin
            state_q <= S_DONE;
            we_q    <= (op == OP_MTHI) ? WE_HI : WE_LO;
            wdata_q <= {src_a, src_a};
          end else begin
            state_q <= is_mul ? S_MUL : S_DIV;
          end
        end
        S_MUL, S_DIV: begin
          if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            cnt_q   <= '0;
            we_q    <= WE_BOTH;
            wdata_q <= final_res;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // MF is held in DONE too, so it cannot read ahead of the negedge write.
  assign stall       = op_valid && is_hilo_op(op) && (state_q != S_IDLE);
  assign busy        = busy_q;
  assign hilo_we     = we_q;
  assign hilo_wdata  = wdata_q;
  assign hilo_rd_sel = (op == OP_MFHI);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: timeline/arithmetic model checked every cycle plus directed literal vectors.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         stall, busy, hilo_rd_sel;
  logic [1:0]   hilo_we;
  logic [63:0]  hilo_wdata;

  int n_chk = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .hilo_we     (hilo_we),
    .hilo_wdata  (hilo_wdata),
    .hilo_rd_sel (hilo_rd_sel)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
  endtask

  // Architectural result of an op: {we, {HI,LO}}.
  function automatic logic [65:0] ref_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] d;
    logic [1:0]  we;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    we = 2'b11;
    d  = '0;
    case (o)
      OP_MTHI:  begin we = 2'b10; d = {a, a}; end
      OP_MTLO:  begin we = 2'b01; d = {a, a}; end
      OP_MULT:  d = sa * sb;
      OP_MULTU: d = {32'd0, a} * {32'd0, b};
      OP_DIV:   if (b == 32'd0) d = {a, 32'hFFFF_FFFF};
                else begin q = sa / sb; r = sa % sb; d = {r[31:0], q[31:0]}; end
      OP_DIVU:  if (b == 32'd0) d = {a, 32'hFFFF_FFFF};
                else d = {a % b, a / b};
      default:  we = 2'b00;
    endcase
    return {we, d};
  endfunction

  // Model: cycles of busy left including the current one; the last one is the write cycle.
  int          m_left;
  logic [1:0]  m_we;
  logic [63:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_left <= 0;
    else if (m_left > 0) m_left <= (flush && m_left > 1) ? 0 : m_left - 1;
    else if (op_valid && !flush && op >= 4'd3 && op <= 4'd8) begin
      m_left <= (op >= 4'd5) ? 33 : 1;
      {m_we, m_data} <= ref_op(op, src_a, src_b);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("hilo_we", 64'(hilo_we), 64'((m_left == 1) ? m_we : 2'b00));
      chk("stall", 64'(stall), 64'(op_valid && op >= 4'd1 && op <= 4'd8 && m_left > 0));
      chk("rd_sel", 64'(hilo_rd_sel), 64'(op == 4'd1));
      if (m_left == 1) chk("wdata", hilo_wdata, m_data);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic run(input string nm, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                     input int lat_exp, input logic [1:0] we_exp, input logic [63:0] d_exp);
    int lat;
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    tick;
    op_valid = 1'b0; op = 4'd0; src_a = '0; src_b = '0;
    lat = 1;
    while (hilo_we == 2'b00 && lat < 40) begin
      tick;
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'(lat_exp));
    chk({nm, "_we"}, 64'(hilo_we), 64'(we_exp));
    chk({nm, "_data"}, hilo_wdata, d_exp);
    tick;
    chk({nm, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish (%0d/%0d so far)", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int k;
    int wrote;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_we", 64'(hilo_we), 64'd0);
    chk("rst_wdata", hilo_wdata, 64'd0);

    run("mult",  OP_MULT,  32'hFFFF_FFFF, 32'h2,  33, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE);
    run("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h2,  33, 2'b11, 64'h0000_0001_FFFF_FFFE);
    run("div_n7", OP_DIV,  32'hFFFF_FFF9, 32'h2,  33, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD);
    run("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 2'b11, 64'h0000_0000_8000_0000);
    run("divu_z", OP_DIVU, 32'h0000_1234, 32'h0,  33, 2'b11, 64'h0000_1234_FFFF_FFFF);
    run("div_z",  OP_DIV,  32'h8000_0000, 32'h0,  33, 2'b11, 64'h8000_0000_FFFF_FFFF);
    run("mtlo",  OP_MTLO,  32'hCAFE_BABE, 32'h0,  1,  2'b01, 64'hCAFE_BABE_CAFE_BABE);
    run("mthi",  OP_MTHI,  32'h1234_5678, 32'h9,  1,  2'b10, 64'h1234_5678_1234_5678);
    run("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 33, 2'b11, 64'h4000_0000_0000_0000);
    run("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'h5, 33, 2'b11, 64'hFFFF_FFFF_FFFF_FFF1);
    run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 2'b11, 64'hFFFF_FFFE_0000_0001);
    run("divu_10", OP_DIVU, 32'hFFFF_FFFF, 32'd10, 33, 2'b11, 64'h0000_0005_1999_9999);
    run("div_7m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 33, 2'b11, 64'h0000_0001_FFFF_FFFD);

    // MULT then MFHI right behind it: stall for 33 cycles, then a new MULT goes straight in.
    op_valid = 1'b1; op = OP_MULT; src_a = 32'd3; src_b = 32'd4;
    tick;
    op = OP_MFHI;
    k = 0;
    while (stall && k < 50) begin
      tick;
      k++;
    end
    chk("b2b_stall_len", 64'(k), 64'd33);
    chk("b2b_rd_sel", 64'(hilo_rd_sel), 64'd1);
    op = OP_MULT; src_a = 32'd7; src_b = 32'd6;
    chk("b2b_nostall", 64'(stall), 64'd0);
    tick;
    op_valid = 1'b0; op = 4'd0;
    chk("b2b_accept", 64'(busy), 64'd1);
    k = 0;
    while (busy && k < 50) begin
      tick;
      k++;
    end
    chk("b2b_len", 64'(k), 64'd33);

    // Flush at N+10 of a DIV aborts it with no write.
    op_valid = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    tick;
    op_valid = 1'b0; op = 4'd0;
    repeat (9) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_idle", 64'(busy), 64'd0);
    wrote = 0;
    repeat (30) begin
      tick;
      if (hilo_we != 2'b00) wrote = 1;
    end
    chk("flush_nowrite", 64'(wrote), 64'd0);
    run("post_flush", OP_MULT, 32'd6, 32'd7, 33, 2'b11, 64'd42);

    // Flush beats accept in IDLE; op 9 and MF in IDLE are not accepted.
    op_valid = 1'b1; op = OP_MULT; src_a = 32'd2; src_b = 32'd2; flush = 1'b1;
    tick;
    flush = 1'b0; op_valid = 1'b0;
    chk("flush_accept", 64'(busy), 64'd0);
    op_valid = 1'b1; op = 4'd9;
    chk("op9_stall", 64'(stall), 64'd0);
    tick;
    chk("op9_idle", 64'(busy), 64'd0);
    op = OP_MFLO;
    chk("mflo_sel", 64'(hilo_rd_sel), 64'd0);
    tick;
    chk("mflo_idle", 64'(busy), 64'd0);
    op_valid = 1'b0; op = 4'd0;

    // Reset in the middle of a MULT.
    op_valid = 1'b1; op = OP_MULT; src_a = 32'd5; src_b = 32'd5;
    tick;
    op_valid = 1'b0; op = 4'd0;
    repeat (19) tick;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_we", 64'(hilo_we), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wrote = 0;
    repeat (40) begin
      tick;
      if (hilo_we != 2'b00 || busy) wrote = 1;
    end
    chk("rst_nowrite", 64'(wrote), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the pipeline's HI/LO register pair. It accepts multiply, divide, move-to and move-from requests from the EX stage and runs 32-cycle iterative signed/unsigned multiply or restoring divide. It drives the HI/LO write strobe, data and read select, and stalls the pipeline while a HI/LO operation is in flight. It sits between the EX-stage decode and the HI/LO storage block, which writes on the falling clock edge and reads combinationally.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH
- CNT_W, 5, iteration counter width (log2 WIDTH)

- clk  in  1  clock, rising-edge logic
- rst_n  in  1  asynchronous, active-low reset
- op_valid  in  1  EX-stage request valid
- op  in  4  operation code (package enum)
- src_a  in  WIDTH  rs value (dividend / multiplicand / MT source)
- src_b  in  WIDTH  rt value (divisor / multiplier)
- flush  in  1  pipeline flush; aborts an in-progress MUL/DIV
- stall  out  1  combinational; hold EX stage this cycle
- busy  out  1  registered; high whenever state != IDLE
- hilo_we  out  2  registered; 01 = write LO, 10 = write HI, 11 = write {HI,LO}, 00 = none
- hilo_wdata  out  2*WIDTH  registered; {HI,LO} write data (MT data on both halves)
- hilo_rd_sel  out  1  combinational; 1 = HI, 0 = LO (read select for MFHI/MFLO)

## Operation
- Op codes: NOP 0, MFHI 1, MFLO 2, MTHI 3, MTLO 4, MULT 5, MULTU 6, DIV 7, DIVU 8; 9–15 are treated as NOP.
- Accept: op_valid && state == IDLE && op is not NOP/MF.
- States:
  - IDLE: on accept of MULT/MULTU, go to MUL. On accept of DIV/DIVU, go to DIV. On accept of MTHI/MTLO, go to DONE.
  - MUL/DIV: one shift-add or shift-subtract step per cycle; count 0..31. At count == 31, go to DONE.
  - DONE: hilo_we and hilo_wdata are valid for exactly this one cycle, then go to IDLE.
- hilo_we values in DONE:
  - MUL/DIV: 11.
  - MTHI: 10, with hilo_wdata = {src_a, src_a} captured at accept.
  - MTLO: 01, with the same data rule.
- stall = op_valid && op in {MF*, MT*, MULT*, DIV*} && state != IDLE.
  - MF is stalled in DONE, so a read never races the pending negedge write.
- hilo_rd_sel = (op == MFHI); MF in IDLE needs no controller action.
- Signed ops:
  - Operands are converted to magnitudes at accept; the unsigned core iterates.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - The most-negative input is handled correctly: its magnitude is carried as a WIDTH+1 or unsigned value.
- Results: HI = remainder / high product; LO = quotient / low product.
- Divide by zero (both DIV and DIVU): HI = src_a unchanged, LO = all ones. The op still takes the full 33-cycle latency.

## Timing
- Reset (async assert, deassert synchronous to clk):
  - state = IDLE, counter = 0, hilo_we = 00, hilo_wdata = 0, busy = 0.
  - stall and hilo_rd_sel then follow their combinational equations.
- MUL/DIV latency: accepted at rising edge N; busy is high from N+1; DONE (hilo_we = 11) in cycle N+33; IDLE at N+34. An op arriving at N+34 is accepted without stall.
- MT latency: accepted at N; DONE in N+1; IDLE at N+2.
- flush:
  - In MUL/DIV: the next state is IDLE, no write occurs, and the operand registers are not required to clear.
  - In DONE: ignored; the write commits.
  - In IDLE: suppresses accept that cycle.
- Simultaneous flush and accept in IDLE: flush wins.
- Reset mid-operation: immediate IDLE, no write, hilo_we = 00.
- Back-to-back ops: the second op sees stall until the first op's DONE cycle has passed.

## Structure
- Package muldiv_pkg holds:
  - the op enum (4-bit);
  - the state enum (IDLE, MUL, DIV, DONE);
  - the hilo_we encoding constants WE_NONE / WE_LO / WE_HI / WE_BOTH;
  - WIDTH default.
- Sub-module muldiv_iter_core: an unsigned 32-step shift-add / restoring-divide datapath with start, mode, and 64-bit result. The controller owns the FSM, sign handling, flush, and HI/LO interface.

## Test plan
- MULT src_a = 0xFFFFFFFF, src_b = 0x00000002 → in cycle N+33, hilo_we = 11, hilo_wdata = 0xFFFFFFFF_FFFFFFFE. MULTU with the same operands → 0x00000001_FFFFFFFE.
- DIV src_a = 0xFFFFFFF9 (−7), src_b = 2 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFD. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU src_a = 0x1234, src_b = 0 → HI = 0x00001234, LO = 0xFFFFFFFF, still at cycle N+33.
- MULT followed immediately by MFHI → stall held for cycles N+1 through N+33, drops at N+34; hilo_rd_sel = 1. MTLO 0xCAFEBABE → hilo_we = 01 at N+1.
- flush asserted at cycle N+10 of a DIV → IDLE at N+11, hilo_we stays 00 throughout, and the next MULT is accepted normally.
- rst_n pulsed low at cycle N+20 of a MULT → busy = 0 and hilo_we = 00 immediately, no write after release.
